// File: rtl/sudoku_pkg.sv
// ============================================================================
// Package : sudoku_pkg
// Brief   : Grid constants, FSM state encoding and result codes shared by the
//           move-capture stage and its sub-modules.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package sudoku_pkg;

    localparam int N_LADO   = 9;
    localparam int W_CELULA = 4;
    localparam int SUDOKU_W = N_LADO * N_LADO * W_CELULA;

    typedef enum logic [2:0] {
        RECEBE_LINHA  = 3'd0,
        RECEBE_COLUNA = 3'd1,
        RECEBE_VALOR  = 3'd2,
        CHECA_POS     = 3'd3,
        VERIFICA      = 3'd4,
        FIM           = 3'd5
    } estado_t;

    localparam logic [2:0] COD_CONTINUA = 3'b100;
    localparam logic [2:0] COD_VITORIA  = 3'b101;
    localparam logic [2:0] COD_DERROTA  = 3'b110;

    localparam logic [1:0] RES_JOGANDO = 2'b00;
    localparam logic [1:0] RES_VITORIA = 2'b01;
    localparam logic [1:0] RES_DERROTA = 2'b10;

    // A switch value is a legal grid coordinate/entry when it lies in 1..N_LADO.
    function automatic logic entrada_valida(input logic [3:0] v);
        return (v != 4'd0) && (v <= 4'(N_LADO));
    endfunction

endpackage

`default_nettype wire

// File: rtl/detector_borda.sv
// ============================================================================
// Module : detector_borda
// Brief  : Registered rising-edge detector; one-cycle pulse per 0->1 change.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic entrada,
    output logic borda
);

    logic r_anterior;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anterior <= 1'b0;
            borda      <= 1'b0;
        end else begin
            r_anterior <= entrada;
            borda      <= entrada & ~r_anterior;
        end
    end

endmodule

`default_nettype wire

// File: rtl/captura_jogada.sv
// ============================================================================
// Module : captura_jogada
// Brief  : Collects row/column/value from the switches, checks the target cell
//          is empty and hands the move to the verifier. Macro
//          CAPTURA_TIMEOUT_EN adds a verifier-response watchdog.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module captura_jogada
    import sudoku_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 64
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                botaoConfirma,
    input  logic [3:0]          chaves,
    input  logic [0:SUDOKU_W-1] sudokuJogador,
    input  logic [2:0]          saidaValor,
    input  logic                rstnRegistradores,
    output logic [3:0]          regLinha,
    output logic [3:0]          regColuna,
    output logic [3:0]          regValor,
    output logic [3:0]          regPosValida,
    output logic                enableVerifica,
    output logic                erroEntrada,
    output logic [1:0]          resultado,
    output logic [2:0]          estado
);

    estado_t               r_estado;
    logic                  w_press;
    logic                  w_valida;
    logic [8:0]            w_lin_m1;
    logic [8:0]            w_col_m1;
    logic [8:0]            w_indice;
    logic [W_CELULA-1:0]   w_celula;

`ifdef CAPTURA_TIMEOUT_EN
    localparam int W_CONT = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    logic [W_CONT-1:0] r_cont;
`endif

    detector_borda u_detector_borda (
        .clk     (clk),
        .rst     (rst),
        .entrada (botaoConfirma),
        .borda   (w_press)
    );

    assign w_valida = entrada_valida(chaves);
    assign w_lin_m1 = {5'd0, regLinha} - 9'd1;
    assign w_col_m1 = {5'd0, regColuna} - 9'd1;
    assign w_indice = w_lin_m1 * 9'(N_LADO * W_CELULA) + w_col_m1 * 9'(W_CELULA);
    assign w_celula = sudokuJogador[w_indice +: W_CELULA];
    assign estado   = r_estado;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado       <= RECEBE_LINHA;
            regLinha       <= 4'd0;
            regColuna      <= 4'd0;
            regValor       <= 4'd0;
            regPosValida   <= 4'd0;
            enableVerifica <= 1'b0;
            erroEntrada    <= 1'b0;
            resultado      <= RES_JOGANDO;
`ifdef CAPTURA_TIMEOUT_EN
            r_cont         <= '0;
`endif
        end else begin
            erroEntrada <= 1'b0;
            case (r_estado)
                RECEBE_LINHA: begin
                    if (w_press) begin
                        if (w_valida) begin
                            regLinha <= chaves;
                            r_estado <= RECEBE_COLUNA;
                        end else begin
                            erroEntrada <= 1'b1;
                        end
                    end
                end
                RECEBE_COLUNA, RECEBE_VALOR: begin
                    if (w_press) begin
                        if (w_valida) begin
                            if (r_estado == RECEBE_COLUNA) begin
                                regColuna <= chaves;
                                r_estado  <= RECEBE_VALOR;
                            end else begin
                                regValor <= chaves;
                                r_estado <= CHECA_POS;
                            end
                        end else if (chaves == 4'd0) begin
                            // Zero on the switches cancels the move in progress
                            regLinha  <= 4'd0;
                            regColuna <= 4'd0;
                            regValor  <= 4'd0;
                            r_estado  <= RECEBE_LINHA;
                        end else begin
                            erroEntrada <= 1'b1;
                        end
                    end
                end
                CHECA_POS: begin
                    if (w_celula == '0) begin
                        regPosValida   <= 4'b0001;
                        enableVerifica <= 1'b1;
                        r_estado       <= VERIFICA;
`ifdef CAPTURA_TIMEOUT_EN
                        r_cont         <= '0;
`endif
                    end else begin
                        regLinha     <= 4'd0;
                        regColuna    <= 4'd0;
                        regValor     <= 4'd0;
                        regPosValida <= 4'd0;
                        erroEntrada  <= 1'b1;
                        r_estado     <= RECEBE_LINHA;
                    end
                end
                VERIFICA: begin
`ifdef CAPTURA_TIMEOUT_EN
                    r_cont <= r_cont + 1'b1;
`endif
                    if (saidaValor == COD_VITORIA) begin
                        enableVerifica <= 1'b0;
                        resultado      <= RES_VITORIA;
                        r_estado       <= FIM;
                    end else if (saidaValor == COD_DERROTA) begin
                        enableVerifica <= 1'b0;
                        resultado      <= RES_DERROTA;
                        r_estado       <= FIM;
                    end else if (!rstnRegistradores) begin
                        // Verifier needs to observe all-zero registers while enabled
                        regLinha     <= 4'd0;
                        regColuna    <= 4'd0;
                        regValor     <= 4'd0;
                        regPosValida <= 4'd0;
                    end else if (saidaValor == COD_CONTINUA) begin
                        enableVerifica <= 1'b0;
                        r_estado       <= RECEBE_LINHA;
                    end
`ifdef CAPTURA_TIMEOUT_EN
                    else if (r_cont == W_CONT'(TIMEOUT_CICLOS - 1)) begin
                        regLinha       <= 4'd0;
                        regColuna      <= 4'd0;
                        regValor       <= 4'd0;
                        regPosValida   <= 4'd0;
                        enableVerifica <= 1'b0;
                        erroEntrada    <= 1'b1;
                        r_estado       <= RECEBE_LINHA;
                    end
`endif
                end
                FIM: begin
                end
                default: r_estado <= RECEBE_LINHA;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_captura_jogada.sv
// ============================================================================
// Module : tb_captura_jogada
// Brief  : Directed stimulus; every change of the DUT output set is checked
//          against a queue of hand-computed expected snapshots.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_captura_jogada;

    typedef struct packed {
        logic [2:0] est;
        logic [3:0] lin;
        logic [3:0] col;
        logic [3:0] val;
        logic [3:0] pos;
        logic       en;
        logic       err;
        logic [1:0] res;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         botaoConfirma;
    logic [3:0]   chaves;
    logic [0:323] sudokuJogador;
    logic [2:0]   saidaValor;
    logic         rstnRegistradores;
    logic [3:0]   regLinha, regColuna, regValor, regPosValida;
    logic         enableVerifica, erroEntrada;
    logic [1:0]   resultado;
    logic [2:0]   estado;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_on = 1'b0;

    always #5 clk = ~clk;

    captura_jogada #(.TIMEOUT_CICLOS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .botaoConfirma     (botaoConfirma),
        .chaves            (chaves),
        .sudokuJogador     (sudokuJogador),
        .saidaValor        (saidaValor),
        .rstnRegistradores (rstnRegistradores),
        .regLinha          (regLinha),
        .regColuna         (regColuna),
        .regValor          (regValor),
        .regPosValida      (regPosValida),
        .enableVerifica    (enableVerifica),
        .erroEntrada       (erroEntrada),
        .resultado         (resultado),
        .estado            (estado)
    );

    function automatic void push(input logic [2:0] est, input logic [3:0] lin,
                                 input logic [3:0] col, input logic [3:0] val,
                                 input logic [3:0] pos, input logic en,
                                 input logic err, input logic [1:0] res, input int dt);
        exp_t e;
        e.s  = '{est: est, lin: lin, col: col, val: val, pos: pos, en: en, err: err, res: res};
        e.dt = dt;
        exp_q.push_back(e);
    endfunction

    // Monitor: every change of the output snapshot is one DUT event
    initial begin
        snap_t cur, prev;
        bit    have_prev = 1'b0;
        int    last_ev   = 0;
        exp_t  e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_on) begin
                cur = '{est: estado, lin: regLinha, col: regColuna, val: regValor,
                        pos: regPosValida, en: enableVerifica, err: erroEntrada, res: resultado};
                if (!have_prev || cur !== prev) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event cyc=%0d: got est=%0d lin=%0d col=%0d val=%0d pos=%0d en=%0b err=%0b res=%0d, required no change",
                                 cyc, cur.est, cur.lin, cur.col, cur.val, cur.pos, cur.en, cur.err, cur.res);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e.s) begin
                            n_err++;
                            $display("FAIL snapshot cyc=%0d: got est=%0d lin=%0d col=%0d val=%0d pos=%0d en=%0b err=%0b res=%0d, required est=%0d lin=%0d col=%0d val=%0d pos=%0d en=%0b err=%0b res=%0d",
                                     cyc, cur.est, cur.lin, cur.col, cur.val, cur.pos, cur.en, cur.err, cur.res,
                                     e.s.est, e.s.lin, e.s.col, e.s.val, e.s.pos, e.s.en, e.s.err, e.s.res);
                        end
                        if (e.dt != 0) begin
                            n_chk++;
                            if (cyc - last_ev != e.dt) begin
                                n_err++;
                                $display("FAIL event_spacing cyc=%0d: got %0d cycles, required %0d",
                                         cyc, cyc - last_ev, e.dt);
                            end
                        end
                    end
                    last_ev   = cyc;
                    prev      = cur;
                    have_prev = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Detector registers the level on the first edge, FSM acts on the second
    task automatic press(input logic [3:0] v);
        chaves        = v;
        botaoConfirma = 1'b1;
        @(posedge clk);
        #1 botaoConfirma = 1'b0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst               = 1'b1;
        botaoConfirma     = 1'b0;
        chaves            = 4'd0;
        sudokuJogador     = '0;
        saidaValor        = 3'b000;
        rstnRegistradores = 1'b1;
        tick(3);

        // Reset state
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        mon_on = 1'b1;
        rst    = 1'b0;
        tick(2);

        // 1: empty grid, move (3,5)=7, verifier continues
        push(3'd1, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd2, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd3, 4'd3, 4'd5, 4'd7, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd4, 4'd3, 4'd5, 4'd7, 4'd1, 1'b1, 1'b0, 2'd0, 1);
        press(4'd3);
        press(4'd5);
        press(4'd7);
        push(3'd0, 4'd3, 4'd5, 4'd7, 4'd1, 1'b0, 1'b0, 2'd0, 1);
        saidaValor = 3'b100;
        tick(1);
        saidaValor = 3'b000;
        tick(2);

        // 2: occupied cell (1,1)=4
        begin
            logic [0:323] g;
            g        = '0;
            g[0:3]   = 4'b0100;
            sudokuJogador = g;
        end
        push(3'd1, 4'd1, 4'd5, 4'd7, 4'd1, 1'b0, 1'b0, 2'd0, 0);
        push(3'd2, 4'd1, 4'd1, 4'd7, 4'd1, 1'b0, 1'b0, 2'd0, 0);
        push(3'd3, 4'd1, 4'd1, 4'd9, 4'd1, 1'b0, 1'b0, 2'd0, 0);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 1);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1);
        press(4'd1);
        press(4'd1);
        press(4'd9);
        tick(2);
        sudokuJogador = '0;

        // 3: invalid row entries, then cancel from column
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 0);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 0);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1);
        push(3'd1, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        press(4'd12);
        press(4'd0);
        press(4'd2);
        press(4'd0);
        tick(2);

        // 4: clear request while verifying, then victory; FIM is frozen
        push(3'd1, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd2, 4'd2, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd3, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd4, 4'd2, 4'd3, 4'd4, 4'd1, 1'b1, 1'b0, 2'd0, 1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        push(3'd4, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'd0, 1);
        rstnRegistradores = 1'b0;
        tick(1);
        rstnRegistradores = 1'b1;
        push(3'd5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd1, 1);
        saidaValor = 3'b101;
        tick(1);
        saidaValor = 3'b000;
        press(4'd1);
        press(4'd5);
        tick(5);

        // 5: defeat code and reset in the same cycle; reset dominates
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        push(3'd1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd2, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd3, 4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd4, 4'd1, 4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 2'd0, 1);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1);
        saidaValor = 3'b110;
        rst        = 1'b1;
        tick(1);
        rst        = 1'b0;
        saidaValor = 3'b000;
        tick(2);

        // 6: verifier silent
        push(3'd1, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd2, 4'd4, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd3, 4'd4, 4'd5, 4'd6, 4'd0, 1'b0, 1'b0, 2'd0, 0);
        push(3'd4, 4'd4, 4'd5, 4'd6, 4'd1, 1'b1, 1'b0, 2'd0, 1);
`ifdef CAPTURA_TIMEOUT_EN
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 8);
        push(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1);
        press(4'd4);
        press(4'd5);
        press(4'd6);
        tick(12);
`else
        press(4'd4);
        press(4'd5);
        press(4'd6);
        tick(100);
        n_chk++;
        if (estado !== 3'd4 || enableVerifica !== 1'b1) begin
            n_err++;
            $display("FAIL no_timeout: got estado=%0d en=%0b, required estado=4 en=1",
                     estado, enableVerifica);
        end
        push(3'd0, 4'd4, 4'd5, 4'd6, 4'd1, 1'b0, 1'b0, 2'd0, 0);
        saidaValor = 3'b100;
        tick(1);
        saidaValor = 3'b000;
        tick(2);
`endif

        // Drain: every expected event must have been observed
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d expected events unobserved, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/captura_jogada.md
Name: captura_jogada

Overview:
Upstream stage of the move verifier. It collects row, column and value from the 4-bit switch bank, one value per confirm-button press. It checks that the addressed cell of the player grid is empty, then drives the verifier's enable and register inputs. It also obeys the verifier's clear request and result codes, and holds the game-over state.

Parameters:
N_LADO, 9, grid side; legal entries are 1..N_LADO.
W_CELULA, 4, bits per cell.
SUDOKU_W, 324, grid vector width (N_LADO*N_LADO*W_CELULA), derived, not overridable.
TIMEOUT_CICLOS, 64, verifier response watchdog limit (used only with the optional feature).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  reset, synchronous, active-high.
botaoConfirma  in  1  confirm button, already synchronised/debounced level.
chaves  in  4  switch value.
sudokuJogador  in  [0:323]  player grid; cell (l,c) is at [(l-1)*36+(c-1)*4 +:4]; 0 means empty.
saidaValor  in  3  verifier result code.
rstnRegistradores  in  1  verifier clear request, active-low.
regLinha, regColuna, regValor  out  4 each  captured move.
regPosValida  out  4  4'b0001 when the target cell is empty, else 0.
enableVerifica  out  1  enable to the verifier.
erroEntrada  out  1  one-cycle pulse on a rejected entry.
resultado  out  2  00 playing, 01 won, 10 lost.
estado  out  3  current FSM state, for display.

Behaviour:
- Reset (rst=1 at a clock edge, dominates everything): all reg*, enableVerifica, erroEntrada and resultado = 0; estado = RECEBE_LINHA; the edge-detector history is cleared.
- Press = rising edge of botaoConfirma (current level 1, previous level 0). One press is one event. Presses in CHECA_POS, VERIFICA and FIM are discarded, not queued.
- RECEBE_LINHA: on a press with chaves in 1..9, regLinha <= chaves and go to RECEBE_COLUNA. On a press with chaves = 0 or 10..15, pulse erroEntrada and stay.
- RECEBE_COLUNA and RECEBE_VALOR: on a press with chaves in 1..9, capture into regColuna or regValor and advance (RECEBE_VALOR advances to CHECA_POS).
- In those two states, a press with chaves = 0 cancels: clear regLinha, regColuna and regValor, go to RECEBE_LINHA, no error pulse. A press with chaves in 10..15 pulses erroEntrada and stays.
- CHECA_POS (exactly 1 cycle): index = (regLinha-1)*36 + (regColuna-1)*4, computed at 9-bit width.
  - If the cell is 0: regPosValida <= 4'b0001, enableVerifica <= 1, go to VERIFICA.
  - Otherwise: clear all reg*, pulse erroEntrada, go to RECEBE_LINHA.
- Latency: the press on the value entry reaches enableVerifica=1 two clock edges later.
- VERIFICA: enableVerifica is held at 1. Checks are made in this priority order each cycle:
  - saidaValor = 3'b101: enableVerifica <= 0, resultado <= 01, go to FIM.
  - saidaValor = 3'b110: enableVerifica <= 0, resultado <= 10, go to FIM.
  - rstnRegistradores = 0: clear all reg* to 0 and stay in VERIFICA. This is required so the verifier can see all-zero registers.
  - saidaValor = 3'b100: enableVerifica <= 0 and go to RECEBE_LINHA.
- FIM: outputs frozen, exits only on rst.
- A press landing in the same cycle as the CHECA_POS→VERIFICA transition is ignored.
- erroEntrada is never high in two consecutive cycles from a single press.

Optional Feature:
- Macro: CAPTURA_TIMEOUT_EN.
- Defined: a cycle counter runs in VERIFICA and restarts on each entry. If TIMEOUT_CICLOS cycles pass with no terminating code, then clear all reg*, set enableVerifica <= 0, pulse erroEntrada and go to RECEBE_LINHA.
- Undefined: no counter; VERIFICA waits indefinitely.

Decomposition:
- Package sudoku_pkg holds:
  - constants N_LADO, W_CELULA, SUDOKU_W;
  - the FSM state encoding: RECEBE_LINHA=0, RECEBE_COLUNA=1, RECEBE_VALOR=2, CHECA_POS=3, VERIFICA=4, FIM=5;
  - result-code constants COD_CONTINUA=3'b100, COD_VITORIA=3'b101, COD_DERROTA=3'b110;
  - resultado encodings.
- One sub-module, detector_borda: a registered rising-edge detector with synchronous active-high reset.

Test Plan:
1. Empty grid; press with chaves 3, then 5, then 7, then hold saidaValor=100 → regLinha=3, regColuna=5, regValor=7, regPosValida=1, enableVerifica=1 two edges after the third press; then enableVerifica=0 and estado=RECEBE_LINHA.
2. Cell (1,1)=4 (bits [0:3]=0100), enter 1,1,9 → erroEntrada pulses one cycle, all reg*=0, estado=RECEBE_LINHA, enableVerifica stays 0.
3. Entries 12 and 0 in RECEBE_LINHA → two erroEntrada pulses, stays. Row 2, then column 0 → cancel: regLinha=0, no error pulse.
4. In VERIFICA, drive rstnRegistradores=0 for 1 cycle, then saidaValor=101 → reg* cleared while enableVerifica=1; then resultado=01, estado=FIM, enableVerifica=0. Further presses and rst=0 leave it unchanged.
5. In VERIFICA, drive saidaValor=110 with rst=1 in the same cycle → reset wins: resultado=00, estado=RECEBE_LINHA.
6. With CAPTURA_TIMEOUT_EN and TIMEOUT_CICLOS=8, saidaValor held at 000 → after 8 cycles: enableVerifica=0, erroEntrada pulse, estado=RECEBE_LINHA. Without the macro → still in VERIFICA after 100 cycles.
